// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// mem_arb_pkg - shared encodings for the mem_system arbiter (rev 1.0)
// ------------------------------------------------------------------
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  localparam logic OP_RD = 1'b0;
  localparam logic OP_WR = 1'b1;

endpackage
`default_nettype wire

// File: rtl/mem_arb_pick.sv
`default_nettype none
// ------------------------------------------------------------------
// mem_arb_pick - combinational winner select (rev 1.0)
// Round-robin on contention when MEM_ARB_RR_EN is defined.
// ------------------------------------------------------------------
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic i_rd,
  input  logic d_req,
`ifdef MEM_ARB_RR_EN
  input  logic last_grant,
`endif
  output logic grant_valid,
  output logic grant_owner
);

  always_comb begin
    grant_valid = i_rd | d_req;
    grant_owner = OWN_D;
    if (i_rd && d_req) begin
`ifdef MEM_ARB_RR_EN
      // On contention the port not served last wins.
      grant_owner = (last_grant == OWN_D) ? OWN_I : OWN_D;
`else
      grant_owner = OWN_D;
`endif
    end else if (i_rd) begin
      grant_owner = OWN_I;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ------------------------------------------------------------------
// mem_arbiter - fetch/data front end for a single mem_system (rev 1.0)
// Define MEM_ARB_RR_EN for round-robin arbitration instead of data priority.
// ------------------------------------------------------------------
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_rd,
  input  logic [15:0] i_addr,
  output logic        i_done,
  output logic [15:0] i_rdata,
  output logic        i_hit,
  input  logic        d_rd,
  input  logic        d_wr,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic        d_done,
  output logic [15:0] d_rdata,
  output logic        d_hit,
  output logic [15:0] m_addr,
  output logic [15:0] m_din,
  output logic        m_rd,
  output logic        m_wr,
  input  logic        m_done,
  input  logic        m_stall,
  input  logic        m_hit,
  input  logic        m_err,
  input  logic [15:0] m_dout,
  output logic        busy,
  output logic        err
);

  localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT_CYC);

  state_t      state_q, state_d;
  logic        owner_q, owner_d;
  logic        op_q, op_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] i_rdata_q, i_rdata_d;
  logic [15:0] d_rdata_q, d_rdata_d;
  logic        i_done_q, i_done_d;
  logic        d_done_q, d_done_d;
  logic        i_hit_q, i_hit_d;
  logic        d_hit_q, d_hit_d;
  logic        busy_q, busy_d;
  logic        err_q, err_d;
  logic [7:0]  wdog_q, wdog_d;

  logic d_req;
  logic grant_valid;
  logic grant_owner;

  assign d_req = d_rd | d_wr;

`ifdef MEM_ARB_RR_EN
  logic last_grant_q, last_grant_d;

  mem_arb_pick u_pick (
    .i_rd        (i_rd),
    .d_req       (d_req),
    .last_grant  (last_grant_q),
    .grant_valid (grant_valid),
    .grant_owner (grant_owner)
  );

  assign last_grant_d = (state_q == IDLE && grant_valid) ? grant_owner : last_grant_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) last_grant_q <= OWN_D;
    else      last_grant_q <= last_grant_d;
  end
`else
  mem_arb_pick u_pick (
    .i_rd        (i_rd),
    .d_req       (d_req),
    .grant_valid (grant_valid),
    .grant_owner (grant_owner)
  );
`endif

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    op_d      = op_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wdog_d    = wdog_q;
    err_d     = err_q | m_err;
    i_done_d  = 1'b0;
    d_done_d  = 1'b0;
    i_rdata_d = '0;
    d_rdata_d = '0;
    i_hit_d   = 1'b0;
    d_hit_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (d_rd && d_wr) err_d = 1'b1;
        if (grant_valid) begin
          state_d = ISSUE;
          owner_d = grant_owner;
          if (grant_owner == OWN_D) begin
            op_d    = d_wr ? OP_WR : OP_RD;
            addr_d  = d_addr;
            wdata_d = d_wdata;
          end else begin
            op_d    = OP_RD;
            addr_d  = i_addr;
            wdata_d = '0;
          end
        end
      end
      ISSUE: begin
        if (!m_stall) begin
          state_d = WAIT;
          wdog_d  = '0;
        end
      end
      WAIT: begin
        if (m_done) begin
          state_d = RESP;
          if (owner_q == OWN_I) begin
            i_done_d  = 1'b1;
            i_rdata_d = m_dout;
            i_hit_d   = m_hit;
          end else begin
            d_done_d  = 1'b1;
            d_rdata_d = m_dout;
            d_hit_d   = m_hit;
          end
        end else if (wdog_q != TO_LIMIT) begin
          // Saturates at the limit: the hang stays flagged, no synthetic done.
          wdog_d = wdog_q + 8'd1;
          if (wdog_d == TO_LIMIT) err_d = 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      owner_q   <= OWN_I;
      op_q      <= OP_RD;
      addr_q    <= '0;
      wdata_q   <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      i_done_q  <= 1'b0;
      d_done_q  <= 1'b0;
      i_hit_q   <= 1'b0;
      d_hit_q   <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
      wdog_q    <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      op_q      <= op_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      i_done_q  <= i_done_d;
      d_done_q  <= d_done_d;
      i_hit_q   <= i_hit_d;
      d_hit_q   <= d_hit_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
      wdog_q    <= wdog_d;
    end
  end

  // Strobes are decoded so a stall cancels them in the same cycle.
  assign m_rd    = (state_q == ISSUE) && !m_stall && (op_q == OP_RD);
  assign m_wr    = (state_q == ISSUE) && !m_stall && (op_q == OP_WR);
  assign m_addr  = addr_q;
  assign m_din   = wdata_q;
  assign i_done  = i_done_q;
  assign i_rdata = i_rdata_q;
  assign i_hit   = i_hit_q;
  assign d_done  = d_done_q;
  assign d_rdata = d_rdata_q;
  assign d_hit   = d_hit_q;
  assign busy    = busy_q;
  assign err     = err_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_mem_arbiter - directed bench with a behavioural mem_system (rev 1.0)
// ------------------------------------------------------------------
module tb_mem_arbiter;

  localparam int TO = 16;

  logic        clk     = 1'b0;
  logic        rst     = 1'b0;
  logic        i_rd    = 1'b0;
  logic [15:0] i_addr  = '0;
  logic        d_rd    = 1'b0;
  logic        d_wr    = 1'b0;
  logic [15:0] d_addr  = '0;
  logic [15:0] d_wdata = '0;
  logic        m_done  = 1'b0;
  logic        m_stall = 1'b0;
  logic        m_hit   = 1'b0;
  logic        m_err   = 1'b0;
  logic [15:0] m_dout  = '0;

  logic        i_done, i_hit, d_done, d_hit, m_rd, m_wr, busy, err;
  logic [15:0] i_rdata, d_rdata, m_addr, m_din;

  int total = 0;
  int passed = 0;
  int fails = 0;
  int rd_pulses = 0;
  int wr_pulses = 0;
  int lat_next = 1;   // cycles from strobe to Done; 0 = never completes

  always #5 clk = ~clk;

  mem_arbiter #(.TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst),
    .i_rd(i_rd), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata), .i_hit(i_hit),
    .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done), .d_rdata(d_rdata), .d_hit(d_hit),
    .m_addr(m_addr), .m_din(m_din), .m_rd(m_rd), .m_wr(m_wr),
    .m_done(m_done), .m_stall(m_stall), .m_hit(m_hit), .m_err(m_err), .m_dout(m_dout),
    .busy(busy), .err(err)
  );

  // Behavioural mem_system: samples strobes mid-cycle, answers lat_next cycles later.
  logic [15:0] mem [logic [15:0]];
  initial begin
    int          cnt;
    logic [15:0] pend_dout;
    logic        pend_hit;
    cnt = 0;
    pend_dout = '0;
    pend_hit = 1'b0;
    mem[16'h0040] = 16'hBEEF;
    forever begin
      @(negedge clk);
      #2;
      m_done = 1'b0;
      m_hit  = !pend_hit;
      m_dout = 16'hDEAD;
      if (!rst) begin
        cnt = 0;
      end else begin
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin
            m_done = 1'b1;
            m_hit  = pend_hit;
            m_dout = pend_dout;
          end
        end
        if (m_rd || m_wr) begin
          if (m_rd) rd_pulses++;
          if (m_wr) wr_pulses++;
          pend_dout = m_rd ? (mem.exists(m_addr) ? mem[m_addr] : 16'h0000) : m_din;
          if (m_wr) mem[m_addr] = m_din;
          pend_hit = (lat_next == 1);
          cnt = lat_next;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input int start, output int n, output logic all_busy);
    n = start;
    all_busy = 1'b1;
    do begin
      @(negedge clk);
      n++;
      all_busy &= busy;
    end while (!(i_done || d_done) && n < 100);
    check("done_seen", {15'h0, i_done | d_done}, 16'h0001);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    #1 rst = 1'b1;
  endtask

  initial begin
    #50000;
    $display("FAIL global_timeout: observed no finish, required finish");
    $fatal(1);
  end

  initial begin
    int   n;
    logic ab;
    int   rd0, wr0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_flags", {8'h0, busy, err, i_done, d_done, i_hit, d_hit, m_rd, m_wr}, 16'h0000);
    check("rst_m_addr", m_addr, 16'h0000);
    check("rst_m_din", m_din, 16'h0000);
    check("rst_rdata", i_rdata | d_rdata, 16'h0000);
    #1 rst = 1'b1;
    @(negedge clk);

    // Fetch hit: strobe in cycle 1, done in cycle 3
    lat_next = 1; i_addr = 16'h0040; i_rd = 1'b1;
    @(negedge clk);
    check("hit_strobe_c1", {14'h0, m_rd, m_wr}, 16'h0002);
    check("hit_m_addr", m_addr, 16'h0040);
    wait_done(1, n, ab);
    check("hit_latency", 16'(n), 16'd3);
    check("hit_i_rdata", i_rdata, 16'hBEEF);
    check("hit_flags", {12'h0, i_done, i_hit, d_done, d_hit}, 16'h000C);
    i_rd = 1'b0;
    @(negedge clk);
    check("hit_back_idle", {14'h0, busy, i_done}, 16'h0000);

    // Data write then read back
    rd0 = rd_pulses; wr0 = wr_pulses;
    d_addr = 16'h1230; d_wdata = 16'h5A5A; d_wr = 1'b1;
    wait_done(0, n, ab);
    check("wr_latency", 16'(n), 16'd3);
    check("wr_owner", {14'h0, i_done, d_done}, 16'h0001);
    d_wr = 1'b0;
    @(negedge clk);
    d_rd = 1'b1;
    wait_done(0, n, ab);
    check("rd_latency", 16'(n), 16'd3);
    check("rd_d_rdata", d_rdata, 16'h5A5A);
    check("rd_flags", {13'h0, i_done, d_done, d_hit}, 16'h0003);
    d_rd = 1'b0;
    check("wr_pulses", 16'(wr_pulses - wr0), 16'd1);
    check("rd_pulses", 16'(rd_pulses - rd0), 16'd1);

    // Contention, twice; second service follows at the minimum 4-cycle period
    for (int r = 0; r < 2; r++) begin
      @(negedge clk);
      lat_next = 1; i_addr = 16'h0040; d_addr = 16'h1230;
      i_rd = 1'b1; d_rd = 1'b1;
      wait_done(0, n, ab);
      check("cont_first_lat", 16'(n), 16'd3);
`ifdef MEM_ARB_RR_EN
      check("cont_first_owner", {14'h0, i_done, d_done}, 16'h0002);
      check("cont_first_data", i_rdata, 16'hBEEF);
      i_rd = 1'b0;
      wait_done(0, n, ab);
      check("cont_period", 16'(n), 16'd4);
      check("cont_second_owner", {14'h0, i_done, d_done}, 16'h0001);
      check("cont_second_data", d_rdata, 16'h5A5A);
      d_rd = 1'b0;
`else
      check("cont_first_owner", {14'h0, i_done, d_done}, 16'h0001);
      check("cont_first_data", d_rdata, 16'h5A5A);
      d_rd = 1'b0;
      wait_done(0, n, ab);
      check("cont_period", 16'(n), 16'd4);
      check("cont_second_owner", {14'h0, i_done, d_done}, 16'h0002);
      check("cont_second_data", i_rdata, 16'hBEEF);
      i_rd = 1'b0;
`endif
    end

    // Clean miss on fetch: 3 + 7
    @(negedge clk);
    lat_next = 8; i_addr = 16'h0040; i_rd = 1'b1;
    wait_done(0, n, ab);
    check("clean_latency", 16'(n), 16'd10);
    check("clean_data_hit", {i_rdata[14:0], i_hit}, {16'hBEEF} << 1);
    i_rd = 1'b0;

    // Dirty miss: write to the same index, then read the other tag
    @(negedge clk);
    lat_next = 1; d_addr = 16'h2230; d_wdata = 16'h7777; d_wr = 1'b1;
    wait_done(0, n, ab);
    d_wr = 1'b0;
    @(negedge clk);
    lat_next = 12; d_addr = 16'h1230; d_rd = 1'b1;
    wait_done(0, n, ab);
    check("dirty_latency", 16'(n), 16'd14);
    check("dirty_busy_held", {15'h0, ab}, 16'h0001);
    check("dirty_d_rdata", d_rdata, 16'h5A5A);
    check("dirty_d_hit", {15'h0, d_hit}, 16'h0000);
    d_rd = 1'b0;

    // Stall holds ISSUE without a strobe
    @(negedge clk);
    lat_next = 1; m_stall = 1'b1; i_addr = 16'h0040; i_rd = 1'b1;
    @(negedge clk);
    check("stall_c1", {13'h0, m_rd, m_wr, busy}, 16'h0001);
    @(negedge clk);
    check("stall_c2", {13'h0, m_rd, m_wr, busy}, 16'h0001);
    m_stall = 1'b0;
    #1;
    check("stall_release", {14'h0, m_rd, m_wr}, 16'h0002);
    wait_done(2, n, ab);
    check("stall_latency", 16'(n), 16'd4);
    check("stall_i_rdata", i_rdata, 16'hBEEF);
    i_rd = 1'b0;

    // Asynchronous reset in the middle of a miss
    @(negedge clk);
    lat_next = 12; i_addr = 16'h0040; i_rd = 1'b1;
    repeat (3) @(negedge clk);
    check("pre_rst_busy", {15'h0, busy}, 16'h0001);
    #1 rst = 1'b0;
    #1;
    check("async_rst_flags", {8'h0, busy, err, i_done, d_done, i_hit, d_hit, m_rd, m_wr}, 16'h0000);
    check("async_rst_m_addr", m_addr, 16'h0000);
    i_rd = 1'b0;
    @(negedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    lat_next = 1; i_rd = 1'b1;
    wait_done(0, n, ab);
    check("post_rst_latency", 16'(n), 16'd3);
    check("post_rst_data", i_rdata, 16'hBEEF);
    check("post_rst_err", {15'h0, err}, 16'h0000);
    i_rd = 1'b0;

    // d_rd and d_wr together: error plus a write
    @(negedge clk);
    rd0 = rd_pulses; wr0 = wr_pulses;
    lat_next = 1; d_addr = 16'h3000; d_wdata = 16'h1111; d_rd = 1'b1; d_wr = 1'b1;
    @(negedge clk);
    check("rdwr_strobe", {13'h0, m_rd, m_wr, err}, 16'h0003);
    check("rdwr_m_din", m_din, 16'h1111);
    wait_done(1, n, ab);
    check("rdwr_latency", 16'(n), 16'd3);
    d_rd = 1'b0; d_wr = 1'b0;
    check("rdwr_pulses", 16'((wr_pulses - wr0) * 16 + (rd_pulses - rd0)), 16'h0010);
    do_reset();
    check("rdwr_err_cleared", {15'h0, err}, 16'h0000);

    // m_err is sticky
    @(negedge clk);
    m_err = 1'b1;
    @(negedge clk);
    m_err = 1'b0;
    check("m_err_sets", {15'h0, err}, 16'h0001);
    repeat (3) @(negedge clk);
    check("m_err_sticky", {14'h0, busy, err}, 16'h0001);
    do_reset();

    // Watchdog: err appears TO cycles after WAIT entry (cycle TO+2), no done
    @(negedge clk);
    lat_next = 0; i_addr = 16'h0040; i_rd = 1'b1;
    repeat (TO + 1) @(negedge clk);
    check("wdog_before", {15'h0, err}, 16'h0000);
    @(negedge clk);
    check("wdog_fire", {15'h0, err}, 16'h0001);
    repeat (5) @(negedge clk);
    check("wdog_hang", {13'h0, busy, err, i_done}, 16'h0006);
    i_rd = 1'b0;
    do_reset();
    check("final_idle", {14'h0, busy, err}, 16'h0000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
